// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving a registered common data bus.
// Define CDB_STATS_EN to build the saturating grant/conflict counters.
module cdb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      flush,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_id,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [2:0]                cdb_src,
  output logic                      cdb_conflict,
  output logic [NUM_REQ*16-1:0]     stat_grants,
  output logic [15:0]               stat_conflicts
);

  logic [2:0]        rr_ptr;
  logic [2:0]        winner;
  logic [2:0]        ptr_nxt;
  logic [2:0]        hi;
  logic [2:0]        lo;
  logic              hi_found;
  logic              grant;
  logic              conflict;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_value;

  // Lowest valid index at/above the pointer wins, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi       = '0;
    lo       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo = 3'(i);
        if (3'(i) >= rr_ptr) begin
          hi       = 3'(i);
          hi_found = 1'b1;
        end
      end
    end
    winner = hi_found ? hi : lo;
  end

  always_comb begin
    grant     = (|req_valid) && !flush;
    req_ready = '0;
    win_tag   = '0;
    win_value = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == 3'(i)) begin
        req_ready[i] = grant;
        win_tag      = req_tag[i*TAG_W +: TAG_W];
        win_value    = req_value[i*DATA_W +: DATA_W];
      end
    end
    ptr_nxt  = (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
    conflict = |(req_valid & (req_valid - NUM_REQ'(1)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid    <= 1'b0;
      cdb_id       <= '0;
      cdb_value    <= '0;
      cdb_src      <= '0;
      cdb_conflict <= 1'b0;
      rr_ptr       <= '0;
    end else begin
      cdb_valid    <= grant;
      cdb_conflict <= conflict;
      if (grant) begin
        cdb_id    <= win_tag;
        cdb_value <= win_value;
        cdb_src   <= winner;
        rr_ptr    <= ptr_nxt;
      end
    end
  end

`ifdef CDB_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];
  logic [15:0] conf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      conf_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && grant_cnt[i] != 16'hFFFF)
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
      if (conflict && conf_cnt != 16'hFFFF)
        conf_cnt <= conf_cnt + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = grant_cnt[g];
  end
  assign stat_conflicts = conf_cnt;
`else
  assign stat_grants    = '0;
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
// Counter checks follow the CDB_STATS_EN build setting.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [8:0]  req_tag = '0;
  logic [95:0] req_value = '0;
  logic [2:0]  req_ready;
  logic        flush = 1'b0;
  logic        cdb_valid;
  logic [2:0]  cdb_id;
  logic [31:0] cdb_value;
  logic [2:0]  cdb_src;
  logic        cdb_conflict;
  logic [47:0] stat_grants;
  logic [15:0] stat_conflicts;

  int n_pass = 0;
  int n_total = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_tag(req_tag),
    .req_value(req_value), .req_ready(req_ready),
    .flush(flush), .cdb_valid(cdb_valid),
    .cdb_id(cdb_id), .cdb_value(cdb_value),
    .cdb_src(cdb_src), .cdb_conflict(cdb_conflict),
    .stat_grants(stat_grants),
    .stat_conflicts(stat_conflicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive at negedge, check grant, then check registered bus.
  task automatic step(input logic [2:0] v, input logic f,
                      input logic [2:0] exp_rdy, input logic exp_vld,
                      input logic [2:0] exp_src, input logic exp_cf);
    @(negedge clk);
    req_valid = v;
    flush = f;
    #1 check("ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
    check("valid", 64'(cdb_valid), 64'(exp_vld));
    check("src", 64'(cdb_src), 64'(exp_src));
    check("conflict", 64'(cdb_conflict), 64'(exp_cf));
  endtask

  initial begin
    logic [2:0] rr_seq [6];
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    #3;
    check("rst_valid", 64'(cdb_valid), 64'd0);
    check("rst_id", 64'(cdb_id), 64'd0);
    check("rst_value", 64'(cdb_value), 64'd0);
    check("rst_src", 64'(cdb_src), 64'd0);
    check("rst_conf", 64'(cdb_conflict), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    req_tag   = {3'd3, 3'd2, 3'd5};
    req_value = {32'h300, 32'h200, 32'hDEADBEEF};
    step(3'b001, 1'b0, 3'b001, 1'b1, 3'd0, 1'b0);
    check("t1_id", 64'(cdb_id), 64'd5);
    check("t1_value", 64'(cdb_value), 64'hDEADBEEF);
    step(3'b000, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0);
    check("t1_hold_id", 64'(cdb_id), 64'd5);

    do_reset();
    for (int k = 0; k < 6; k++)
      step(3'b111, 1'b0, rr_seq[k], 1'b1, 3'(k % 3), 1'b1);
    check("rr_id", 64'(cdb_id), 64'd3);
    check("rr_value", 64'(cdb_value), 64'h300);
`ifdef CDB_STATS_EN
    check("stat_g", 64'(stat_grants), {16'd0, 16'd2, 16'd2, 16'd2});
    check("stat_c", 64'(stat_conflicts), 64'd6);
`else
    check("stat_g0", 64'(stat_grants), 64'd0);
    check("stat_c0", 64'(stat_conflicts), 64'd0);
`endif

    // Pointer at 0: grant 1 moves it to 2, then 011 wraps to 0.
    step(3'b010, 1'b0, 3'b010, 1'b1, 3'd1, 1'b0);
    step(3'b011, 1'b0, 3'b001, 1'b1, 3'd0, 1'b1);
    step(3'b011, 1'b0, 3'b010, 1'b1, 3'd1, 1'b1);

    // Pointer at 2: flush holds it, conflict still sampled.
    step(3'b111, 1'b1, 3'b000, 1'b0, 3'd1, 1'b1);
    step(3'b111, 1'b0, 3'b100, 1'b1, 3'd2, 1'b1);
    step(3'b010, 1'b1, 3'b000, 1'b0, 3'd2, 1'b0);
    step(3'b010, 1'b0, 3'b010, 1'b1, 3'd1, 1'b0);

    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(cdb_valid), 64'd0);
    check("arst_id", 64'(cdb_id), 64'd0);
    check("arst_value", 64'(cdb_value), 64'd0);
    check("arst_src", 64'(cdb_src), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #0;
    step(3'b100, 1'b0, 3'b100, 1'b1, 3'd2, 1'b0);
    check("post_id", 64'(cdb_id), 64'd3);

`ifdef CDB_STATS_EN
    do_reset();
    @(negedge clk);
    req_valid = 3'b001;
    repeat (70000) @(posedge clk);
    #1 check("sat", 64'(stat_grants[15:0]), 64'hFFFF);
    req_valid = '0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter that shares one common data bus (CDB) among NUM_REQ functional-unit result ports.
- Requesters are, for example, the integer ALU, the branch unit and the mult/div unit.
- The winner's ROB tag and value are registered onto the CDB, where the ROB, the reservation stations and decode-stage operand capture snoop them.
- Speculation flush blocks all grants for that cycle.

Parameters:
- NUM_REQ, 3, number of requesting functional units (legal range 1..8)
- TAG_W, 3, ROB tag width (8-entry ROB)
- DATA_W, 32, result value width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  requester i holds a completed result
- req_tag  in  NUM_REQ*TAG_W  ROB tag for requester i, in slice [i*TAG_W +: TAG_W]
- req_value  in  NUM_REQ*DATA_W  result for requester i, in slice [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant, combinational
- flush  in  1  speculation flush (decode flush_ctrl)
- cdb_valid  out  1  registered CDB strobe
- cdb_id  out  TAG_W  registered ROB tag
- cdb_value  out  DATA_W  registered result
- cdb_src  out  3  index of the winning requester
- cdb_conflict  out  1  registered flag: more than one requester was valid in the previous cycle
- stat_grants  out  NUM_REQ*16  per-requester grant counters (see Optional Feature)
- stat_conflicts  out  16  conflict-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - cdb_valid=0, cdb_id=0, cdb_value=0, cdb_src=0, cdb_conflict=0.
  - rr_ptr=0; stat counters=0.
  - Reset asserted mid-transfer discards the transfer; requesters must re-present.
- Grant (combinational):
  - Scan req_valid starting at rr_ptr, ascending with wrap-around modulo NUM_REQ.
  - The first valid requester wins; req_ready is one-hot on the winner.
  - req_ready is all-zero when no requester is valid or when flush=1.
  - req_ready never depends on cdb_valid; the CDB has no backpressure.
- Transfer: a transfer occurs when req_valid[i] & req_ready[i]. The requester drops or advances its result in the next cycle.
- Requester rule: once req_valid is asserted, tag and value are held stable until ready.
- Output register, next edge after a transfer:
  - cdb_valid=1, cdb_id=tag, cdb_value=value, cdb_src=i.
  - Latency is exactly 1 cycle.
- Output register, no transfer: cdb_valid=0; cdb_id, cdb_value and cdb_src hold their last values.
- Pointer:
  - On a transfer, rr_ptr <= (i+1) mod NUM_REQ, so after NUM_REQ-1 the pointer wraps to 0.
  - With no transfer, or during flush, rr_ptr is unchanged.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles when flush is low.
- Flush:
  - No grant in the flush cycle; cdb_valid=0 on the following edge.
  - A result registered in the cycle before flush is still broadcast; the CDB itself never squashes.
  - Requesters are responsible for dropping their own speculative results.
- cdb_conflict: registered popcount(req_valid)>1, sampled every cycle, including flush cycles.
- NUM_REQ=1: a valid requester is granted every cycle unless flush is high; rr_ptr stays 0.
- Duplicate tags from two requesters are not checked; both are broadcast in grant order.

Optional Feature:
- Macro: CDB_STATS_EN.
- Defined:
  - stat_grants slice i increments by 1 on each transfer from requester i.
  - stat_conflicts increments by 1 each cycle where popcount(req_valid)>1.
  - All counters are 16-bit, saturate at 16'hFFFF, and clear only on reset.
- Undefined: stat_grants and stat_conflicts are tied to 0 and no counter flops are built. Port list is identical in both builds.

Test Plan:
- Reset, then req_valid=3'b001, tag0=5, value0=32'hDEADBEEF -> req_ready=3'b001 in the same cycle; next cycle cdb_valid=1, cdb_id=5, cdb_value=32'hDEADBEEF, cdb_src=0; the cycle after, cdb_valid=0.
- req_valid=3'b111 held for 6 cycles from reset -> grants in order 0,1,2,0,1,2; cdb_conflict=1 from cycle 2; with CDB_STATS_EN, each stat_grants slice=2 and stat_conflicts=6.
- rr_ptr=2 (after a grant to 1), req_valid=3'b011 -> requester 0 is granted (wrap); rr_ptr becomes 1.
- req_valid=3'b010 with flush=1 for one cycle -> req_ready=0, cdb_valid=0 next cycle, rr_ptr unchanged; with flush=0 the next cycle requester 1 is granted.
- rst driven low while cdb_valid=1 -> all outputs 0 immediately, without waiting for a clock edge; after rst=1, req_valid=3'b100 -> requester 2 granted first cycle.
- CDB_STATS_EN build, requester 0 granted 70000 times -> stat_grants[15:0]=16'hFFFF (saturated, no wrap).
